// File: rtl/adc_sequencer_if.sv
// Bundle of the ADC handshake, control, status and result-stream signals seen by adc_sequencer.
// master is the sequencer's view; slave is the view of whatever surrounds it.
interface adc_sequencer_if #(
    parameter int RESOLUTION = 8,
    parameter int DEPTH      = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                  en_i;
    logic [15:0]           period_i;
    logic                  clr_i;
    logic                  start_o;
    logic                  rdy_i;
    logic [RESOLUTION-1:0] result_i;
    logic [RESOLUTION-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [LW-1:0]         level_o;
    logic                  busy_o;
    logic                  overflow_o;
    logic                  timeout_o;

    modport master (
        input  en_i, period_i, clr_i, rdy_i, result_i, ready_i,
        output start_o, data_o, valid_o, level_o, busy_o, overflow_o, timeout_o
    );

    modport slave (
        output en_i, period_i, clr_i, rdy_i, result_i, ready_i,
        input  start_o, data_o, valid_o, level_o, busy_o, overflow_o, timeout_o
    );
endinterface

// File: rtl/adc_sequencer.sv
// Periodic SAR ADC start/rdy initiator with a result FIFO; ADC_AVG_EN pushes 2^AVG_LOG2-sample averages.
// Latency: a captured result appears on data_o one cycle after the capture edge.
// Backpressure: valid/ready output; a capture arriving at a full FIFO is dropped and sets overflow_o.
module adc_sequencer #(
    parameter int RESOLUTION     = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int AVG_LOG2       = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    adc_sequencer_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("adc_sequencer: DEPTH must be a power of two, at least 2");
        end
        if (AVG_LOG2 < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("adc_sequencer: AVG_LOG2 and TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RDY  = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t                state;
    logic [TW-1:0]         tcnt;
    logic [15:0]           pcnt;
    logic                  waiting;
    logic                  progress;
    logic                  tmo;
    logic                  capture;
    logic                  elapsed;
    logic                  push;
    logic [RESOLUTION-1:0] push_dat;

    logic [RESOLUTION-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [LW-1:0]         count;
    logic                  full;
    logic                  pop;
    logic                  wr;

    assign waiting  = (state == WAIT_RDY) || (state == WAIT_DONE);
    assign progress = (state == WAIT_RDY) ? bus.rdy_i : !bus.rdy_i;
    assign tmo      = waiting && !progress && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign capture  = (state == WAIT_DONE) && !bus.rdy_i;
    // pcnt+1 is the number of cycles since the last start, including the current one
    assign elapsed  = ({1'b0, pcnt} + 17'd1) >= {1'b0, bus.period_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            tcnt          <= '0;
            pcnt          <= '0;
            bus.start_o   <= 1'b0;
            bus.busy_o    <= 1'b0;
            bus.timeout_o <= 1'b0;
        end else begin
            if (pcnt != 16'hFFFF) begin
                pcnt <= pcnt + 16'd1;
            end
            if (waiting) begin
                tcnt <= tcnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.en_i) begin
                        state       <= WAIT_RDY;
                        tcnt        <= '0;
                        pcnt        <= '0;
                        bus.start_o <= 1'b1;
                        bus.busy_o  <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (bus.rdy_i) begin
                        state       <= WAIT_DONE;
                        tcnt        <= '0;
                        bus.start_o <= 1'b0;
                    end else if (tmo) begin
                        state       <= IDLE;
                        tcnt        <= '0;
                        bus.start_o <= 1'b0;
                        bus.busy_o  <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.rdy_i) begin
                        state <= GAP;
                        tcnt  <= '0;
                    end else if (tmo) begin
                        state      <= IDLE;
                        tcnt       <= '0;
                        bus.busy_o <= 1'b0;
                    end
                end
                GAP: begin
                    if (elapsed) begin
                        tcnt <= '0;
                        if (bus.en_i) begin
                            state       <= WAIT_RDY;
                            pcnt        <= '0;
                            bus.start_o <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            bus.busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.start_o <= 1'b0;
                    bus.busy_o  <= 1'b0;
                end
            endcase

            if (tmo) begin
                bus.timeout_o <= 1'b1;
            end else if (bus.clr_i) begin
                bus.timeout_o <= 1'b0;
            end
        end
    end

`ifdef ADC_AVG_EN
    localparam int SW = RESOLUTION + AVG_LOG2;

    logic [SW-1:0]       sum;
    logic [SW-1:0]       sum_nxt;
    logic [AVG_LOG2-1:0] acnt;

    assign sum_nxt  = sum + SW'(bus.result_i);
    assign push     = capture && (acnt == '1);
    assign push_dat = RESOLUTION'(sum_nxt >> AVG_LOG2);

    // a timeout throws away the partial average so a later push never mixes aborted samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum  <= '0;
            acnt <= '0;
        end else if (capture) begin
            if (acnt == '1) begin
                sum  <= '0;
                acnt <= '0;
            end else begin
                sum  <= sum_nxt;
                acnt <= acnt + 1'b1;
            end
        end else if (tmo) begin
            sum  <= '0;
            acnt <= '0;
        end
    end
`else
    assign push     = capture;
    assign push_dat = bus.result_i;
`endif

    assign full = (count == LW'(DEPTH));
    assign pop  = (count != '0) && bus.ready_i;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            bus.overflow_o <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= push_dat;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !wr) begin
                bus.overflow_o <= 1'b1;
            end else if (bus.clr_i) begin
                bus.overflow_o <= 1'b0;
            end
        end
    end

    assign bus.data_o  = mem[rptr];
    assign bus.valid_o = (count != '0);
    assign bus.level_o = count;
endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: ADC responder model, scoreboard queue of expected FIFO output, directed and random phases.
module tb_adc_sequencer;
    localparam int RES      = 8;
    localparam int DEPTH    = 4;
    localparam int TMO      = 64;
    localparam int AVG_LOG2 = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    adc_sequencer_if #(.RESOLUTION(RES), .DEPTH(DEPTH)) bus ();

    adc_sequencer #(
        .RESOLUTION(RES), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [RES-1:0] exp_q[$];
    logic [RES-1:0] adc_res_q[$];
    int  adc_delay = 3;
    int  adc_conv  = 1;
    bit  adc_hang  = 1'b0;
    int  adc_done  = 0;
    int  drop_cyc  = 0;
    int  rise_cnt  = 0;
    int  last_rise = 0;
    logic prev_start = 1'b0;
    bit  rand_ready = 1'b0;
    logic ready_val = 1'b0;
    int  avg_sum = 0;
    int  avg_n   = 0;
    int  base, t_en, first, r, fall_c, d, d0, r0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a bounded queue of what the FIFO should deliver, fed per completed conversion.
    function automatic void model_push(input logic [RES-1:0] v);
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
    endfunction

    function automatic void model_capture(input logic [RES-1:0] v);
`ifdef ADC_AVG_EN
        avg_sum += int'(v);
        avg_n++;
        if (avg_n == (1 << AVG_LOG2)) begin
            model_push(RES'(avg_sum / (1 << AVG_LOG2)));
            avg_sum = 0;
            avg_n   = 0;
        end
`else
        model_push(v);
`endif
    endfunction

    function automatic void model_abort();
        avg_sum = 0;
        avg_n   = 0;
    endfunction

    initial begin : cycle_count
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    initial begin : edge_mon
        forever begin
            @(negedge clk_i);
            if (bus.start_o && !prev_start) begin
                rise_cnt++;
                last_rise = cyc;
            end
            prev_start = bus.start_o;
        end
    end

    initial begin : ready_drv
        bus.ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            bus.ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // ADC controller model: rdy after adc_delay cycles, hold until start drops, then result with rdy low.
    initial begin : adc_model
        logic [RES-1:0] res;
        int k;
        bus.rdy_i    = 1'b0;
        bus.result_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni && bus.start_o && !adc_hang) begin
                repeat (adc_delay - 1) begin
                    @(posedge clk_i);
                    #1;
                end
                bus.rdy_i = 1'b1;
                k = 0;
                while (bus.start_o && k < 200) begin
                    @(posedge clk_i);
                    #1;
                    k++;
                end
                check("adc_start_release", bus.start_o, 0);
                repeat (adc_conv) begin
                    @(posedge clk_i);
                    #1;
                end
                res = (adc_res_q.size() != 0) ? adc_res_q.pop_front() : RES'($urandom);
                bus.result_i = res;
                bus.rdy_i    = 1'b0;
                drop_cyc     = cyc;
                adc_done++;
                model_capture(res);
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_ni && bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got data %0d with no entry expected", bus.data_o);
                end else begin
                    check("pop_data", bus.data_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && bus.busy_o; i++) @(negedge clk_i);
        check({name, "_idle"}, bus.busy_o, 0);
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        for (int i = 0; i < budget && adc_done < target; i++) @(negedge clk_i);
        check({name, "_conversions"}, adc_done >= target, 1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || bus.valid_o); i++) @(negedge clk_i);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_level"}, bus.level_o, 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk_i);
        bus.clr_i = 1'b1;
        @(negedge clk_i);
        bus.clr_i = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.en_i     = 1'b0;
        bus.period_i = 16'd0;
        bus.clr_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_start", bus.start_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_level", bus.level_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_overflow", bus.overflow_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

`ifndef ADC_AVG_EN
        // Periodic launch, latency and start-to-start interval
        ready_val    = 1'b0;
        bus.period_i = 16'd20;
        adc_delay    = 10;
        adc_conv     = 2;
        adc_res_q.push_back(8'hA5);
        adc_res_q.push_back(8'h3C);
        base      = rise_cnt;
        t_en      = cyc;
        bus.en_i  = 1'b1;
        for (int i = 0; i < 10 && rise_cnt <= base; i++) @(negedge clk_i);
        check("t1_first_start_latency", last_rise - t_en, 1);
        first = last_rise;
        for (int i = 0; i < 50 && !bus.valid_o; i++) @(negedge clk_i);
        check("t1_valid", bus.valid_o, 1);
        check("t1_data", bus.data_o, 8'hA5);
        for (int i = 0; i < 40 && rise_cnt <= base + 1; i++) @(negedge clk_i);
        check("t1_period", last_rise - first, 20);
        bus.en_i = 1'b0;
        wait_idle("t1", 100);
        check("t1_level_after_en_drop", bus.level_o, 2);
        ready_val = 1'b1;
        wait_drain("t1", 50);

        // Overflow with a stalled consumer
        ready_val    = 1'b0;
        bus.period_i = 16'd0;
        adc_delay    = 3;
        adc_conv     = 1;
        for (int v = 1; v <= 5; v++) adc_res_q.push_back(RES'(v));
        base     = adc_done;
        bus.en_i = 1'b1;
        wait_done("t2", base + 5, 300);
        bus.en_i = 1'b0;
        wait_idle("t2", 50);
        check("t2_level_full", bus.level_o, 4);
        check("t2_overflow", bus.overflow_o, 1);
        check("t2_head", bus.data_o, 1);
        ready_val = 1'b1;
        wait_drain("t2", 50);
        ready_val = 1'b0;
        check("t2_overflow_sticky", bus.overflow_o, 1);
        pulse_clr();
        check("t2_overflow_cleared", bus.overflow_o, 0);
`else
        // Averaging: four captures give one push of their truncated mean
        ready_val    = 1'b0;
        bus.period_i = 16'd0;
        adc_delay    = 3;
        adc_conv     = 1;
        for (int v = 10; v <= 13; v++) adc_res_q.push_back(RES'(v));
        base     = adc_done;
        bus.en_i = 1'b1;
        wait_done("t6a", base + 3, 200);
        repeat (2) @(negedge clk_i);
        check("t6_no_early_push", bus.level_o, 0);
        wait_done("t6b", base + 4, 100);
        bus.en_i = 1'b0;
        wait_idle("t6", 50);
        check("t6_level", bus.level_o, 1);
        check("t6_avg_data", bus.data_o, 11);
        ready_val = 1'b1;
        wait_drain("t6", 50);
        ready_val = 1'b0;
`endif

        // Handshake timeout: controller never answers
        adc_hang     = 1'b1;
        bus.period_i = 16'd0;
        base         = rise_cnt;
        @(negedge clk_i);
        bus.en_i = 1'b1;
        for (int i = 0; i < 10 && rise_cnt <= base; i++) @(negedge clk_i);
        r = last_rise;
        for (int i = 0; i < 100 && bus.start_o; i++) @(negedge clk_i);
        fall_c = cyc;
        check("t3_start_width", fall_c - r, TMO);
        check("t3_timeout", bus.timeout_o, 1);
        check("t3_level", bus.level_o, 0);
        check("t3_busy", bus.busy_o, 0);
        for (int i = 0; i < 10 && rise_cnt <= base + 1; i++) @(negedge clk_i);
        check("t3_restart_gap", last_rise - fall_c, 1);
        bus.en_i = 1'b0;
        wait_idle("t3", 200);
        model_abort();
        adc_hang = 1'b0;
        pulse_clr();
        check("t3_timeout_cleared", bus.timeout_o, 0);

        // Back-to-back conversions with period 0
        ready_val    = 1'b1;
        bus.period_i = 16'd0;
        adc_delay    = 3;
        adc_conv     = 1;
        bus.en_i     = 1'b1;
        for (int n = 0; n < 4; n++) begin
            d0 = adc_done;
            for (int i = 0; i < 40 && adc_done <= d0; i++) @(negedge clk_i);
            d  = drop_cyc;
            r0 = rise_cnt;
            for (int i = 0; i < 20 && rise_cnt <= r0; i++) @(negedge clk_i);
            check("t4_back_to_back", last_rise - d, 2);
        end
        bus.en_i = 1'b0;
        wait_idle("t4", 50);
        check("t4_no_overflow", bus.overflow_o, 0);
        wait_drain("t4", 50);

        // Randomized periods, latencies, enable drops and consumer stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (!bus.en_i) wait_idle("rnd", 200);
            bus.period_i = 16'($urandom_range(0, 30));
            adc_delay    = $urandom_range(2, 8);
            adc_conv     = $urandom_range(0, 3);
            d0           = adc_done;
            bus.en_i     = 1'b1;
            for (int i = 0; i < 200 && adc_done <= d0; i++) @(negedge clk_i);
            check("rnd_progress", adc_done > d0, 1);
            bus.en_i = ($urandom_range(0, 4) != 0);
        end
        bus.en_i = 1'b0;
        wait_idle("rnd", 200);
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        wait_drain("rnd", 100);
        check("rnd_timeout", bus.timeout_o, 0);
        check("rnd_overflow", bus.overflow_o, 0);

        // Asynchronous reset in WAIT_RDY with two entries queued
        ready_val    = 1'b0;
        bus.period_i = 16'd0;
        adc_delay    = 3;
        adc_conv     = 1;
        bus.en_i     = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() < 2; i++) @(negedge clk_i);
        adc_hang = 1'b1;
        for (int i = 0; i < 20 && !(bus.start_o && bus.level_o == 2); i++) @(negedge clk_i);
        check("t5_pre_level", bus.level_o, 2);
        check("t5_pre_start", bus.start_o, 1);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("t5_start_async", bus.start_o, 0);
        check("t5_valid_async", bus.valid_o, 0);
        check("t5_level_async", bus.level_o, 0);
        exp_q.delete();
        model_abort();
        bus.en_i = 1'b0;
        adc_hang = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check("t5_post_busy", bus.busy_o, 0);
        check("t5_post_valid", bus.valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
